// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Select encodings of the EX-stage operand forwarding muxes.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Width of the mult/div busy counter; holds latencies up to 63.
  localparam int unsigned CNT_W = 6;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } md_state_e;

  // A source depends on a destination only if both name the same non-zero register.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_md_seq.sv
// Mult/div sequencer: tracks the multi-cycle unit with a down-counter, raises
// md_busy for the full latency, pulses md_done in the last busy cycle and flags
// HI/LO readers that must wait.
module hazard_md_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_md_start,
  input  logic ex_md_div,
  input  logic id_rd_hilo,
  output logic md_busy,
  output logic md_done,
  output logic md_hazard
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state: load on start, count down while busy, finish when cnt reaches 1.
  // busy stays high through the done cycle, which is spent back in StIdle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_md_start) begin
          cnt_d   = ex_md_div ? DIV_LOAD : MUL_LOAD;
          state_d = StBusy;
          busy_d  = 1'b1;
        end
      end
      StBusy: begin
        // A start while busy is ignored; the HI/LO stall keeps legal code from doing it.
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q == CNT_W'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign md_busy   = busy_q;
  assign md_done   = done_q;
  // A start in EX already occupies HI/LO, so a reader behind it waits too.
  assign md_hazard = id_rd_hilo & (busy_q | ex_md_start);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use and HI/LO
// stalls for the five-stage core.
// Build option: define HAZARD_FWD_EN to enable EX/MEM forwarding; without it the
// selects stay at the regfile and every RAW dependency on EX/MEM stalls instead.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_rd_hilo,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwr,
  input  logic       ex_memrd,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwr,
  input  logic       ex_md_start,
  input  logic       ex_md_div,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       stall,
  output logic       bubble,
  output logic       md_busy,
  output logic       md_done
);

  logic       ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic       load_use, data_stall, md_hazard;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

  // Register-number comparisons against the two older pipeline stages.
  always_comb begin
    ex_hit_rs  = ex_regwr & reg_match(id_rs, ex_rd);
    ex_hit_rt  = ex_regwr & reg_match(id_rt, ex_rd);
    mem_hit_rs = mem_regwr & reg_match(id_rs, mem_rd);
    mem_hit_rt = mem_regwr & reg_match(id_rt, mem_rd);
    load_use   = ex_memrd & ((id_use_rs & ex_hit_rs) | (id_use_rt & ex_hit_rt));
  end

`ifdef HAZARD_FWD_EN
  // Forward from MEM for an ALU producer in EX, else from WB for a producer in MEM;
  // a load still in EX cannot forward and is covered by the load-use stall.
  always_comb begin
    data_stall = load_use;
    fwd_a_d    = FWD_REG;
    fwd_b_d    = FWD_REG;
    if (ex_hit_rs && !ex_memrd) begin
      fwd_a_d = FWD_MEM;
    end else if (mem_hit_rs) begin
      fwd_a_d = FWD_WB;
    end
    if (ex_hit_rt && !ex_memrd) begin
      fwd_b_d = FWD_MEM;
    end else if (mem_hit_rt) begin
      fwd_b_d = FWD_WB;
    end
  end
`else
  // No forwarding: hold ID until every producer it reads has reached WB.
  always_comb begin
    data_stall = load_use
               | (id_use_rs & (ex_hit_rs | mem_hit_rs))
               | (id_use_rt & (ex_hit_rt | mem_hit_rt));
    fwd_a_d    = FWD_REG;
    fwd_b_d    = FWD_REG;
  end
`endif

  hazard_md_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk         (clk),
    .rst         (rst),
    .ex_md_start (ex_md_start),
    .ex_md_div   (ex_md_div),
    .id_rd_hilo  (id_rd_hilo),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_hazard   (md_hazard)
  );

  assign stall  = data_stall | md_hazard;
  assign bubble = stall;

  // Forward-select registers; a stalled ID sends a bubble into EX, which reads nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else if (stall) begin
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: registered expectations are queued when a step
// is driven and checked after the following clock edge.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, id_rd_hilo;
  logic       ex_regwr, ex_memrd, mem_regwr, ex_md_start, ex_md_div;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, bubble, md_busy, md_done;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  hazard_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd_hilo  (id_rd_hilo),
    .ex_rd       (ex_rd),
    .ex_regwr    (ex_regwr),
    .ex_memrd    (ex_memrd),
    .mem_rd      (mem_rd),
    .mem_regwr   (mem_regwr),
    .ex_md_start (ex_md_start),
    .ex_md_div   (ex_md_div),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .bubble      (bubble),
    .md_busy     (md_busy),
    .md_done     (md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic pipe(input logic [4:0] erd, input logic ewr, input logic eld,
                      input logic [4:0] mrd, input logic mwr,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt);
    ex_rd = erd; ex_regwr = ewr; ex_memrd = eld;
    mem_rd = mrd; mem_regwr = mwr;
    id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
  endtask

  task automatic idle();
    pipe(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    id_rd_hilo = 1'b0; ex_md_start = 1'b0; ex_md_div = 1'b0;
  endtask

  // One cycle: check stall/bubble now, then registered outputs after the edge.
  task automatic cyc(input string tag, input logic e_stall, input logic [1:0] e_fa,
                     input logic [1:0] e_fb, input logic e_busy, input logic e_done);
    exp_t  e;
    string t;
    #1;
    chk({tag, ".stall"}, {1'b0, stall}, {1'b0, e_stall});
    chk({tag, ".bubble"}, {1'b0, bubble}, {1'b0, e_stall});
    sb_q.push_back('{fa: e_fa, fb: e_fb, busy: e_busy, done: e_done});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".fwd_a"}, fwd_a, e.fa);
    chk({t, ".fwd_b"}, fwd_b, e.fb);
    chk({t, ".md_busy"}, {1'b0, md_busy}, {1'b0, e.busy});
    chk({t, ".md_done"}, {1'b0, md_done}, {1'b0, e.done});
  endtask

  initial begin
    idle();
    // Reset has priority over a matching producer and a mult/div start.
    rst = 1'b1;
    pipe(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1);
    ex_md_start = 1'b1;
    cyc("reset_busy", !FWD, 2'b00, 2'b00, 1'b0, 1'b0);
    idle();
    cyc("reset_idle", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;

    // ALU producer r3 in EX, consumer reads rs = r3.
    pipe(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'd4, 1'b1);
`ifdef HAZARD_FWD_EN
    cyc("add_ex", 1'b0, 2'b10, 2'b00, 1'b0, 1'b0);
`else
    cyc("add_nf1", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    pipe(5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1);
    cyc("add_nf2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
`endif
    idle();
    cyc("add_after", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Load r5 in EX, consumer reads rt = r5.
    pipe(5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1);
    cyc("lw_stall", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    pipe(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1);
`ifdef HAZARD_FWD_EN
    cyc("lw_wb", 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
`else
    cyc("lw_nf2", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    pipe(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 5'd5, 1'b1);
    cyc("lw_nf3", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
`endif

    // Register 0 never matches, for ALU or load producers.
    pipe(5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc("r0_alu", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    pipe(5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc("r0_load", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // EX and MEM both write r7: EX wins on both operands.
    pipe(5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1);
    cyc("r7_both", !FWD, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00, 1'b0, 1'b0);
    // rs from MEM, rt from EX.
    pipe(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1);
    cyc("mix", !FWD, FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00, 1'b0, 1'b0);
    // Load matches only a source the instruction does not read.
    pipe(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd1, 1'b1);
    cyc("unused_src", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    // Matching EX destination that does not write.
    pipe(5'd3, 1'b0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1);
    cyc("no_write", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Multiply with a HI/LO reader held in ID.
    idle();
    ex_md_start = 1'b1; ex_md_div = 1'b0; id_rd_hilo = 1'b1;
    cyc("mul_start", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
    ex_md_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc("mul_busy", 1'b1, 2'b00, 2'b00, k < 4, k == 3);
    end
    cyc("mul_free", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Divide: 33 stall cycles; a stray start mid-operation is ignored.
    ex_md_start = 1'b1; ex_md_div = 1'b1;
    cyc("div_start", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      ex_md_start = (k == 5);
      ex_md_div   = 1'b0;
      cyc("div_busy", 1'b1, 2'b00, 2'b00, k < 32, k == 31);
    end
    ex_md_start = 1'b0;
    cyc("div_free", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset during a multiply aborts it with no done pulse.
    idle();
    ex_md_start = 1'b1;
    cyc("mulrst_start", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    ex_md_start = 1'b0;
    cyc("mulrst_b1", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("mulrst_rst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc("mulrst_quiet", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
